// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard controller.
// The pipeline side is the master; the controller side is the slave.
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
) ();
  logic [4:0]       id_rs1_i;
  logic [4:0]       id_rs2_i;
  logic             id_use_rs1_i;
  logic             id_use_rs2_i;
  logic [4:0]       ex_rd_i;
  logic             ex_is_load_i;
  logic             id_redirect_i;
  logic             mem_access_i;
  logic             dmem_ready_i;
  logic             pc_stall_o;
  logic             if_id_stall_o;
  logic             if_id_nop_o;
  logic             id_ex_nop_o;
  logic             freeze_o;
  logic             dmem_req_o;
  logic             mem_err_o;
  logic [CNT_W-1:0] stall_cnt_o;

  modport master (
    output id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i, ex_rd_i, ex_is_load_i,
           id_redirect_i, mem_access_i, dmem_ready_i,
    input  pc_stall_o, if_id_stall_o, if_id_nop_o, id_ex_nop_o, freeze_o,
           dmem_req_o, mem_err_o, stall_cnt_o
  );

  modport slave (
    input  id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i, ex_rd_i, ex_is_load_i,
           id_redirect_i, mem_access_i, dmem_ready_i,
    output pc_stall_o, if_id_stall_o, if_id_nop_o, id_ex_nop_o, freeze_o,
           dmem_req_o, mem_err_o, stall_cnt_o
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer: load-use interlock, ID redirect flush and a data-memory
// wait-state FSM with timeout watchdog, plus a saturating stall-cycle counter.
module pipeline_hazard_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input logic                  clk,
  input logic                  rst_n,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    M_IDLE = 2'd0,
    M_WAIT = 2'd1,
    M_ERR  = 2'd2
  } mem_state_e;

  mem_state_e       state, state_nxt;
  logic [TMR_W-1:0] timer, timer_nxt;
  logic [CNT_W-1:0] stall_cnt;
  logic             freeze, dmem_req, mem_err;
  logic             load_use, pc_stall;
  logic             rs1_hit, rs2_hit;

  // Memory-wait FSM state and watchdog timer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= M_IDLE;
      timer <= '0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
    end
  end

  // Next state and memory-side outputs; freeze lifts in the ack cycle
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    dmem_req  = 1'b0;
    freeze    = 1'b0;
    mem_err   = 1'b0;
    case (state)
      M_IDLE: begin
        dmem_req = bus.mem_access_i;
        if (bus.mem_access_i && !bus.dmem_ready_i) begin
          freeze    = 1'b1;
          state_nxt = M_WAIT;
          timer_nxt = TMR_W'(1);
        end
      end
      M_WAIT: begin
        dmem_req = 1'b1;
        freeze   = !bus.dmem_ready_i;
        if (bus.dmem_ready_i) begin
          state_nxt = M_IDLE;
          timer_nxt = '0;
        end else if (timer == TMR_W'(TIMEOUT)) begin
          state_nxt = M_ERR;
        end else begin
          timer_nxt = timer + TMR_W'(1);
        end
      end
      M_ERR: begin
        freeze  = 1'b1;
        mem_err = 1'b1;
      end
      default: begin
        state_nxt = M_IDLE;
        timer_nxt = '0;
      end
    endcase
  end

  // A load writing x0 never creates a dependency
  assign rs1_hit  = bus.id_use_rs1_i && (bus.id_rs1_i == bus.ex_rd_i);
  assign rs2_hit  = bus.id_use_rs2_i && (bus.id_rs2_i == bus.ex_rd_i);
  assign load_use = bus.ex_is_load_i && (bus.ex_rd_i != 5'd0) && (rs1_hit || rs2_hit);
  assign pc_stall = freeze || load_use;

  // Saturating stall-cycle counter, independent of the FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (pc_stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign bus.pc_stall_o    = pc_stall;
  assign bus.if_id_stall_o = pc_stall;
  assign bus.id_ex_nop_o   = load_use && !freeze;
  assign bus.if_id_nop_o   = bus.id_redirect_i && !load_use && !freeze;
  assign bus.freeze_o      = freeze;
  assign bus.dmem_req_o    = dmem_req;
  assign bus.mem_err_o     = mem_err;
  assign bus.stall_cnt_o   = stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized plus directed bench for pipeline_hazard_ctrl; two instances
// (default sizing and TIMEOUT=4/CNT_W=3) share stimulus against a reference model.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned TO_A = 16;
  localparam int unsigned CW_A = 32;
  localparam int unsigned TO_B = 4;
  localparam int unsigned CW_B = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] rs1, rs2, exrd;
  logic       use1, use2, ld, redir, macc, rdy;

  int n_checks = 0;
  int n_errors = 0;

  // Model: consecutive un-acked request cycles, error flag, stall count
  int              m_n[2];
  bit              m_err[2];
  longint unsigned m_cnt[2];
  longint unsigned m_max[2] = '{64'hFFFF_FFFF, 64'd7};
  int              m_to[2]  = '{TO_A, TO_B};
  string           ctl_name[7] = '{"pc_stall", "if_id_stall", "if_id_nop", "id_ex_nop",
                                   "freeze", "dmem_req", "mem_err"};

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.CNT_W(CW_A)) ifa ();
  pipeline_hazard_ctrl_if #(.CNT_W(CW_B)) ifb ();

  assign ifa.id_rs1_i = rs1;   assign ifb.id_rs1_i = rs1;
  assign ifa.id_rs2_i = rs2;   assign ifb.id_rs2_i = rs2;
  assign ifa.id_use_rs1_i = use1;  assign ifb.id_use_rs1_i = use1;
  assign ifa.id_use_rs2_i = use2;  assign ifb.id_use_rs2_i = use2;
  assign ifa.ex_rd_i = exrd;   assign ifb.ex_rd_i = exrd;
  assign ifa.ex_is_load_i = ld;    assign ifb.ex_is_load_i = ld;
  assign ifa.id_redirect_i = redir; assign ifb.id_redirect_i = redir;
  assign ifa.mem_access_i = macc;  assign ifb.mem_access_i = macc;
  assign ifa.dmem_ready_i = rdy;   assign ifb.dmem_ready_i = rdy;

  pipeline_hazard_ctrl #(.TIMEOUT(TO_A), .CNT_W(CW_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa)
  );
  pipeline_hazard_ctrl #(.TIMEOUT(TO_B), .CNT_W(CW_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] obs_ctl(input int d);
    if (d == 0)
      return {ifa.pc_stall_o, ifa.if_id_stall_o, ifa.if_id_nop_o, ifa.id_ex_nop_o,
              ifa.freeze_o, ifa.dmem_req_o, ifa.mem_err_o};
    return {ifb.pc_stall_o, ifb.if_id_stall_o, ifb.if_id_nop_o, ifb.id_ex_nop_o,
            ifb.freeze_o, ifb.dmem_req_o, ifb.mem_err_o};
  endfunction

  function automatic logic [63:0] obs_cnt(input int d);
    return (d == 0) ? 64'(ifa.stall_cnt_o) : 64'(ifb.stall_cnt_o);
  endfunction

  // Expected controls from the hazard rules and the model's memory status
  function automatic logic [6:0] exp_ctl(input int d);
    bit lu, busy, frz, req, ps;
    lu   = ld && (exrd != 5'd0) && ((use1 && rs1 == exrd) || (use2 && rs2 == exrd));
    busy = (m_n[d] > 0) || macc;
    frz  = m_err[d] || (busy && !rdy);
    req  = !m_err[d] && busy;
    ps   = frz || lu;
    return {ps, ps, redir && !lu && !frz, lu && !frz, frz, req, m_err[d]};
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_n[d] = 0; m_err[d] = 1'b0; m_cnt[d] = 0;
    end
  endtask

  task automatic model_step(input int d);
    logic [6:0] e;
    e = exp_ctl(d);
    if (e[6] && m_cnt[d] < m_max[d]) m_cnt[d]++;
    if (!m_err[d] && (m_n[d] > 0 || macc)) begin
      if (rdy) m_n[d] = 0;
      else begin
        m_n[d]++;
        if (m_n[d] > m_to[d]) m_err[d] = 1'b1;
      end
    end
  endtask

  // Called just after a negedge with inputs set; returns at the next negedge
  task automatic cycle();
    logic [6:0] o, e;
    if (!rst_n) model_reset();
    #1;
    for (int d = 0; d < 2; d++) begin
      o = obs_ctl(d);
      e = exp_ctl(d);
      for (int i = 0; i < 7; i++)
        check($sformatf("%s_%s", (d == 0) ? "a" : "b", ctl_name[i]),
              64'(o[6-i]), 64'(e[6-i]));
      check($sformatf("%s_stall_cnt", (d == 0) ? "a" : "b"), obs_cnt(d), m_cnt[d]);
    end
    if (rst_n) begin
      model_step(0);
      model_step(1);
    end
    @(negedge clk);
  endtask

  task automatic idle_in();
    rs1 = 5'd0; rs2 = 5'd0; exrd = 5'd0;
    use1 = 1'b0; use2 = 1'b0; ld = 1'b0; redir = 1'b0; macc = 1'b0; rdy = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_in();
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    idle_in();
    model_reset();
    @(negedge clk);
    do_reset();
    check("rst_cnt_a", obs_cnt(0), 64'd0);

    // Load-use on rs2
    ld = 1'b1; exrd = 5'd5; use2 = 1'b1; rs2 = 5'd5;
    cycle();
    check("lu_cnt_a", obs_cnt(0), 64'd1);
    // Same pattern through x0 must not stall
    exrd = 5'd0; rs2 = 5'd0;
    cycle();
    check("lu_x0_cnt_a", obs_cnt(0), 64'd1);

    // Redirect alone, then with concurrent load-use on rs1
    idle_in(); redir = 1'b1;
    cycle();
    ld = 1'b1; exrd = 5'd7; use1 = 1'b1; rs1 = 5'd7;
    cycle();
    check("redir_lu_cnt_a", obs_cnt(0), 64'd2);

    // Three wait states then ack
    idle_in(); macc = 1'b1; rdy = 1'b0;
    repeat (3) cycle();
    rdy = 1'b1;
    cycle();
    idle_in();
    cycle();
    check("wait_cnt_a", obs_cnt(0), 64'd5);

    // Hold ready low: b errs after TO_B+1 requests, a after TO_A+1
    macc = 1'b1; rdy = 1'b0;
    repeat (TO_B + 1) cycle();
    check("to_err_b", 64'(ifb.mem_err_o), 64'd1);
    check("to_req_b", 64'(ifb.dmem_req_o), 64'd0);
    macc = 1'b0;
    repeat (TO_A - TO_B) cycle();
    check("to_err_b_hold", 64'(ifb.freeze_o), 64'd1);
    check("to_err_a", 64'(ifa.mem_err_o), 64'd1);
    do_reset();
    check("rst_err_a", 64'(ifa.mem_err_o), 64'd0);

    // Asynchronous reset while waiting
    macc = 1'b1; rdy = 1'b0;
    repeat (2) cycle();
    #3;
    rst_n = 1'b0; macc = 1'b0;
    #1;
    check("async_req_a", 64'(ifa.dmem_req_o), 64'd0);
    check("async_frz_a", 64'(ifa.freeze_o), 64'd0);
    check("async_cnt_a", obs_cnt(0), 64'd0);
    @(negedge clk);
    cycle();
    rst_n = 1'b1;

    // Saturation of the 3-bit counter
    ld = 1'b1; exrd = 5'd9; use1 = 1'b1; rs1 = 5'd9;
    repeat (10) cycle();
    check("sat_cnt_b", obs_cnt(1), 64'd7);
    check("sat_cnt_a", obs_cnt(0), 64'd10);

    // Randomized traffic with occasional resets
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 79) == 0) begin
        do_reset();
      end else begin
        rs1   = 5'($urandom_range(0, 3));
        rs2   = 5'($urandom_range(0, 3));
        exrd  = 5'($urandom_range(0, 3));
        use1  = 1'($urandom_range(0, 1));
        use2  = 1'($urandom_range(0, 1));
        ld    = 1'($urandom_range(0, 1));
        redir = 1'($urandom_range(0, 1));
        macc  = 1'($urandom_range(0, 1));
        rdy   = ($urandom_range(0, 3) != 0);
        cycle();
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage RISC-V pipeline. Combines load-use hazard detection, ID-stage redirect flushing and a data-memory wait-state handshake into per-stage stall/bubble controls for PC, IF_ID, ID_EX and EX_MEM. Runs a memory-wait FSM with a timeout watchdog and a saturating stall-cycle performance counter. Sits beside the pipeline registers; all control outputs are consumed in the same cycle they are produced.

## Interface
- TIMEOUT, 16: number of consecutive un-acked memory-request cycles before error; legal range 1..255.
- CNT_W, 32: width of stall performance counter.

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_rs1_i  in  5  rs1 of instruction in ID
- id_rs2_i  in  5  rs2 of instruction in ID
- id_use_rs1_i  in  1  ID instruction reads rs1
- id_use_rs2_i  in  1  ID instruction reads rs2
- ex_rd_i  in  5  destination of instruction in ID_EX
- ex_is_load_i  in  1  ID_EX instruction is a load
- id_redirect_i  in  1  taken branch/jal resolved in ID
- mem_access_i  in  1  EX_MEM instruction is a valid load/store
- dmem_ready_i  in  1  data memory completes current access
- pc_stall_o  out  1  hold PC
- if_id_stall_o  out  1  hold IF_ID
- if_id_nop_o  out  1  load NOP into IF_ID (flush fetched instruction)
- id_ex_nop_o  out  1  load bubble into ID_EX
- freeze_o  out  1  hold ID_EX and EX_MEM; bubble into writeback
- dmem_req_o  out  1  data memory request
- mem_err_o  out  1  sticky memory-timeout error
- stall_cnt_o  out  CNT_W  saturating count of cycles with pc_stall_o=1

## Operation
- Memory FSM states: M_IDLE, M_WAIT, M_ERR; wait timer width clog2(TIMEOUT+1).
- M_IDLE: dmem_req_o = mem_access_i. If mem_access_i & dmem_ready_i: zero-wait, no freeze, stay. If mem_access_i & !dmem_ready_i: freeze_o=1 this cycle, next state M_WAIT, timer<=1.
- M_WAIT: dmem_req_o=1; freeze_o = !dmem_ready_i. On dmem_ready_i -> M_IDLE, timer<=0 (freeze drops in the ack cycle). Else if timer==TIMEOUT -> M_ERR; else timer+1.
- M_ERR: dmem_req_o=0, freeze_o=1, mem_err_o=1; exit only via reset.
- load_use = ex_is_load_i & ex_rd_i!=0 & ((id_use_rs1_i & id_rs1_i==ex_rd_i) | (id_use_rs2_i & id_rs2_i==ex_rd_i)).
- Priority freeze > load_use > redirect:
  - pc_stall_o = if_id_stall_o = freeze_o | load_use.
  - id_ex_nop_o = load_use & !freeze_o.
  - if_id_nop_o = id_redirect_i & !load_use & !freeze_o.
- Redirect during load_use is ignored this cycle; ID re-presents it next cycle.
- stall_cnt_o increments each cycle pc_stall_o=1; holds at 2^CNT_W-1.

## Timing
- Reset (async, immediate): state M_IDLE, timer 0, mem_err_o 0, stall_cnt_o 0; with idle inputs all control outputs 0. Reset during M_WAIT/M_ERR drops dmem_req_o and freeze_o immediately.
- All control outputs combinational from inputs and current state; zero latency.
- Freeze duration for an access acked on the Nth request cycle (N≥2): N-1 cycles.
- Error: with TIMEOUT un-acked cycles in M_WAIT plus the first M_IDLE cycle, mem_err_o rises on the edge after the (TIMEOUT+1)th request cycle.
- ex_rd_i==0 never causes load-use stall.
- Counter saturation and FSM independent; counter still counts in M_ERR.

## Test plan
- Load-use: ex_is_load_i=1, ex_rd_i=5, id_use_rs2_i=1, id_rs2_i=5 -> pc_stall_o=if_id_stall_o=id_ex_nop_o=1 one cycle, stall_cnt_o 0->1; same with ex_rd_i=0 -> no stall.
- Redirect: id_redirect_i=1, no hazard -> if_id_nop_o=1, no stall; with concurrent load_use -> if_id_nop_o=0, id_ex_nop_o=1.
- Memory wait: mem_access_i=1, dmem_ready_i low 3 cycles then high -> dmem_req_o 1 for 4 cycles, freeze_o 1 for 3, id_ex_nop_o/if_id_nop_o 0 throughout, stall_cnt_o +3.
- Timeout: TIMEOUT=4, dmem_ready_i held 0 -> mem_err_o rises after 5th request cycle, dmem_req_o=0, freeze_o stays 1; rst_n pulse clears all.
- Reset mid-wait: assert rst_n=0 in M_WAIT -> dmem_req_o, freeze_o 0 same cycle; stall_cnt_o 0.
- Saturation: CNT_W=3, continuous stall 10 cycles -> stall_cnt_o stops at 7.
